// File: rtl/sym_vn_rank_core.sv
// Symmetric variable-node LUT core: folded (y0, y1) pair -> bank/page address,
// two-bank double-page-set 4-bit message memory with one write port and two read ports.
module sym_vn_rank_core (
   input  logic       read_clk,
   input  logic       rstn,
   input  logic [2:0] y0_in_A,
   input  logic [3:0] y1_in_A,
   input  logic [2:0] y0_in_B,
   input  logic [3:0] y1_in_B,
   input  logic       read_addr_offset,
   output logic [5:0] page_addr_A,
   output logic [5:0] page_addr_B,
   output logic       bank_addr_A,
   output logic       bank_addr_B,
   output logic [3:0] lut_data0,
   output logic [3:0] lut_data1,
   input  logic [3:0] lut_in_bank0,
   input  logic [3:0] lut_in_bank1,
   input  logic [5:0] page_write_addr,
   input  logic       write_addr_offset,
   input  logic       we
);

   localparam int unsigned MSG_W  = 4;
   localparam int unsigned IDX_W  = 7;
   localparam int unsigned PAGE_W = 6;
   localparam int unsigned ADDR_W = PAGE_W + 1;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   logic [IDX_W-1:0]  idx_a;
   logic [IDX_W-1:0]  idx_b;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [ADDR_W-1:0] wr_addr;
   logic [MSG_W-1:0]  rd_data_a;
   logic [MSG_W-1:0]  rd_data_b;

   logic [MSG_W-1:0] bank0_mem [DEPTH];
   logic [MSG_W-1:0] bank1_mem [DEPTH];

   // Index {y0, y1}: LSB picks the bank, remaining bits the page.
   always_comb begin
      idx_a       = {y0_in_A, y1_in_A};
      idx_b       = {y0_in_B, y1_in_B};
      page_addr_A = idx_a[IDX_W-1:1];
      page_addr_B = idx_b[IDX_W-1:1];
      bank_addr_A = idx_a[0];
      bank_addr_B = idx_b[0];
      rd_addr_a   = {read_addr_offset, idx_a[IDX_W-1:1]};
      rd_addr_b   = {read_addr_offset, idx_b[IDX_W-1:1]};
      wr_addr     = {write_addr_offset, page_write_addr};
   end

   // Read muxes see pre-edge contents, giving old-data read-during-write.
   always_comb begin
      rd_data_a = bank_addr_A ? bank1_mem[rd_addr_a] : bank0_mem[rd_addr_a];
      rd_data_b = bank_addr_B ? bank1_mem[rd_addr_b] : bank0_mem[rd_addr_b];
   end

   // Memory write port; both banks written on the same edge.
   always_ff @(posedge read_clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            bank0_mem[i] <= '0;
            bank1_mem[i] <= '0;
         end
      end else if (we) begin
         bank0_mem[wr_addr] <= lut_in_bank0;
         bank1_mem[wr_addr] <= lut_in_bank1;
      end
   end

   // Registered read results.
   always_ff @(posedge read_clk or negedge rstn) begin
      if (!rstn) begin
         lut_data0 <= '0;
         lut_data1 <= '0;
      end else begin
         lut_data0 <= rd_data_a;
         lut_data1 <= rd_data_b;
      end
   end

endmodule

// File: tb/tb_sym_vn_rank_core.sv
// Directed self-checking bench for sym_vn_rank_core.
module tb_sym_vn_rank_core;

   logic       clk;
   logic       rstn;
   logic [2:0] y0_a, y0_b;
   logic [3:0] y1_a, y1_b;
   logic       rd_off;
   logic [5:0] page_a, page_b;
   logic       bank_a, bank_b;
   logic [3:0] data0, data1;
   logic [3:0] in_b0, in_b1;
   logic [5:0] wr_page;
   logic       wr_off;
   logic       we;

   int n_cmp  = 0;
   int n_fail = 0;

   sym_vn_rank_core dut (
      .read_clk          (clk),
      .rstn              (rstn),
      .y0_in_A           (y0_a),
      .y1_in_A           (y1_a),
      .y0_in_B           (y0_b),
      .y1_in_B           (y1_b),
      .read_addr_offset  (rd_off),
      .page_addr_A       (page_a),
      .page_addr_B       (page_b),
      .bank_addr_A       (bank_a),
      .bank_addr_B       (bank_b),
      .lut_data0         (data0),
      .lut_data1         (data1),
      .lut_in_bank0      (in_b0),
      .lut_in_bank1      (in_b1),
      .page_write_addr   (wr_page),
      .write_addr_offset (wr_off),
      .we                (we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn   = 1'b1;
      y0_a   = 3'd5; y1_a = 4'h9;
      y0_b   = 3'd2; y1_b = 4'h6;
      rd_off = 1'b1;
      in_b0  = 4'hC; in_b1 = 4'hD;
      wr_page = 6'd13; wr_off = 1'b0;
      we     = 1'b1;
      #2 rstn = 1'b0;
      repeat (3) tick();
      check("reset_data0", 8'(data0), 8'h0);
      check("reset_data1", 8'(data1), 8'h0);
      we = 1'b0;
      #5 rstn = 1'b1;

      // Page 0 and 63, bank0 on port A and bank1 on port B, both offsets.
      for (int off = 0; off < 2; off++) begin
         rd_off = off[0];
         y0_a = 3'd0; y1_a = 4'h0; y0_b = 3'd0; y1_b = 4'h1;
         tick();
         check("rst_pg0_b0", 8'(data0), 8'h0);
         check("rst_pg0_b1", 8'(data1), 8'h0);
         y0_a = 3'd7; y1_a = 4'hE; y0_b = 3'd7; y1_b = 4'hF;
         tick();
         check("rst_pg63_b0", 8'(data0), 8'h0);
         check("rst_pg63_b1", 8'(data1), 8'h0);
      end

      // Address mapping.
      y0_a = 3'b001; y1_a = 4'hA; y0_b = 3'b111; y1_b = 4'hF;
      #1;
      check("page_a", 8'(page_a), 8'd13);
      check("bank_a", 8'(bank_a), 8'd0);
      check("page_b", 8'(page_b), 8'd63);
      check("bank_b", 8'(bank_b), 8'd1);

      // Write page 13 offset 0, then read both banks.
      we = 1'b1; wr_page = 6'd13; wr_off = 1'b0; in_b0 = 4'hA; in_b1 = 4'h5;
      tick();
      we = 1'b0;
      y0_a = 3'd1; y1_a = 4'hA; y0_b = 3'd1; y1_b = 4'hB; rd_off = 1'b0;
      tick();
      check("wr_rd_bank0", 8'(data0), 8'hA);
      check("wr_rd_bank1", 8'(data1), 8'h5);

      // Page-set isolation.
      we = 1'b1; wr_off = 1'b1; in_b0 = 4'h7; in_b1 = 4'h3;
      tick();
      we = 1'b0; rd_off = 1'b1;
      tick();
      check("off1_bank0", 8'(data0), 8'h7);
      check("off1_bank1", 8'(data1), 8'h3);
      rd_off = 1'b0;
      tick();
      check("off0_bank0", 8'(data0), 8'hA);
      check("off0_bank1", 8'(data1), 8'h5);

      // Disabled write leaves contents unchanged.
      we = 1'b0; wr_off = 1'b0; in_b0 = 4'hF; in_b1 = 4'hF;
      tick();
      check("we0_off0", 8'(data0), 8'hA);
      rd_off = 1'b1;
      tick();
      check("we0_off1", 8'(data0), 8'h7);

      // Read-during-write returns old data, new data next edge.
      rd_off = 1'b0;
      we = 1'b1; wr_off = 1'b0; in_b0 = 4'h2; in_b1 = 4'h5;
      tick();
      check("rdw_old", 8'(data0), 8'hA);
      we = 1'b0;
      tick();
      check("rdw_new", 8'(data0), 8'h2);
      check("rdw_bank1", 8'(data1), 8'h5);

      // Asynchronous reset mid-operation.
      rstn = 1'b0;
      #1;
      check("async_rst_d0", 8'(data0), 8'h0);
      check("async_rst_d1", 8'(data1), 8'h0);
      #4 rstn = 1'b1;
      tick();
      check("post_rst_pg13_b0", 8'(data0), 8'h0);
      check("post_rst_pg13_b1", 8'(data1), 8'h0);
      rd_off = 1'b1;
      tick();
      check("post_rst_off1_b0", 8'(data0), 8'h0);

      // Write latency after reset: written at edge N, seen after edge N+1.
      rd_off = 1'b0;
      we = 1'b1; wr_off = 1'b0; wr_page = 6'd13; in_b0 = 4'h9; in_b1 = 4'h6;
      tick();
      we = 1'b0;
      tick();
      check("lat_bank0", 8'(data0), 8'h9);
      check("lat_bank1", 8'(data1), 8'h6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
